uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 103 ++++++++++
 tb/tb_uart_tx_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin framer that serialises per-source packets
// (SYNC, HDR, payload, XOR checksum) onto a byte-wide UART transmitter.
module uart_tx_scheduler #(
    parameter int          NUM_SRC   = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          BUSY_TO   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [4*NUM_SRC-1:0]   src_len,
    input  logic [64*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data_out,
    output logic                   tx_start_out,
    output logic                   sched_busy,
    output logic [1:0]             cur_src
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SEND = 3'd2, WAIT_HI = 3'd3, WAIT_LO = 3'd4, ACK = 3'd5;
    localparam int CW = $clog2(BUSY_TO + 1);
    logic [2:0]    state;
    logic [1:0]    grant, last_grant, nxt;
    logic          found;
    logic [2:0]    j;
    logic [3:0]    len, idx, sl;
    logic [7:0]    chk, hdr, cur_byte;
    logic [63:0]   pay;
    logic [CW-1:0] cnt;
    logic          is_chk;
    // Round-robin search: lowest offset from last_grant+1 wins.
    always_comb begin
        nxt = '0;
        found = 1'b0;
        j = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = {1'b0, last_grant} + 3'd1 + 3'(k);
            if (j >= 3'(NUM_SRC)) j = j - 3'(NUM_SRC);
            if (src_req[j[1:0]]) begin
                nxt = j[1:0];
                found = 1'b1;
            end
        end
    end
    assign sl       = src_len[4*grant +: 4];
    assign hdr      = {2'b00, grant, len};
    assign is_chk   = idx == len + 4'd2;
    // Payload register shifts right as bytes go out, so byte 0 is always pay[7:0].
    assign cur_byte = idx == 4'd0 ? SYNC_BYTE : idx == 4'd1 ? hdr : is_chk ? chk : pay[7:0];
    assign tx_start_out = state == SEND;
    assign tx_data_out  = state == SEND ? cur_byte : 8'h00;
    assign sched_busy   = state != IDLE;
    assign cur_src      = state == IDLE ? 2'd0 : grant;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ack
        assign src_ack[i] = state == ACK && grant == 2'(i);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'(NUM_SRC - 1);
            len        <= '0;
            idx        <= '0;
            chk        <= '0;
            cnt        <= '0;
            pay        <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant <= nxt;
                    state <= LOAD;
                end
                LOAD: begin
                    len   <= sl > 4'd8 ? 4'd8 : sl;
                    pay   <= src_data[64*grant +: 64];
                    idx   <= '0;
                    chk   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (idx != 4'd0 && !is_chk) chk <= chk ^ cur_byte;
                    if (idx >= 4'd2 && !is_chk) pay <= pay >> 8;
                    cnt   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy || cnt == CW'(BUSY_TO - 1)) state <= WAIT_LO;
                         else cnt <= cnt + 1'b1;
                WAIT_LO: if (!tx_busy) begin
                    if (is_chk) state <= ACK;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= SEND;
                    end
                end
                ACK: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench; expected bytes/acks are queued when
// stimulus is driven and checked by a monitor on each start pulse and ack.
module tb_uart_tx_scheduler;
    localparam int N = 3;
    localparam int TO = 15;
    logic clk = 1'b0, reset = 1'b1, tx_busy = 1'b0;
    logic [N-1:0] src_req = '0;
    logic [4*N-1:0] src_len = '0;
    logic [64*N-1:0] src_data = '0;
    logic [N-1:0] src_ack;
    logic [7:0] tx_data_out;
    logic tx_start_out, sched_busy;
    logic [1:0] cur_src;
    int vectors = 0, miscompares = 0;
    int busy_len = 10;
    logic [7:0] exp_q[$];
    int src_q[$];
    logic [N-1:0] ack_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_SRC(N), .SYNC_BYTE(8'hA5), .BUSY_TO(TO)) dut (
        .clk(clk), .reset(reset), .src_req(src_req), .src_len(src_len), .src_data(src_data),
        .src_ack(src_ack), .tx_busy(tx_busy), .tx_data_out(tx_data_out),
        .tx_start_out(tx_start_out), .sched_busy(sched_busy), .cur_src(cur_src)
    );

    // UART model: raise busy the cycle after a start and hold it busy_len cycles.
    initial forever begin
        @(negedge clk);
        if (tx_start_out === 1'b1 && busy_len > 0) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
    end

    initial begin
        logic [7:0] e;
        int s;
        logic [N-1:0] a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_start_out === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL start_unexpected: got byte %h, required no start", tx_data_out);
                    end else begin
                        e = exp_q.pop_front();
                        s = src_q.pop_front();
                        if (tx_data_out !== e) begin
                            miscompares++;
                            $display("FAIL tx_byte: got %h, required %h", tx_data_out, e);
                        end
                        vectors++;
                        if (cur_src !== 2'(s)) begin
                            miscompares++;
                            $display("FAIL cur_src: got %0d, required %0d", cur_src, s);
                        end
                    end
                end else begin
                    vectors++;
                    if (tx_data_out !== 8'h00) begin
                        miscompares++;
                        $display("FAIL idle_data: got %h, required 00", tx_data_out);
                    end
                end
                if (src_ack !== '0) begin
                    vectors++;
                    if (ack_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL ack_unexpected: got %b, required none", src_ack);
                    end else begin
                        a = ack_q.pop_front();
                        if (src_ack !== a) begin
                            miscompares++;
                            $display("FAIL src_ack: got %b, required %b", src_ack, a);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    function automatic void push_byte(logic [7:0] b, int s);
        exp_q.push_back(b);
        src_q.push_back(s);
    endfunction

    function automatic void push_frame(int s, logic [3:0] l, logic [63:0] d);
        logic [3:0] c;
        logic [7:0] h, x;
        c = l > 4'd8 ? 4'd8 : l;
        h = {2'b00, 2'(s), c};
        x = h;
        push_byte(8'hA5, s);
        push_byte(h, s);
        for (int i = 0; i < int'(c); i++) begin
            x = x ^ d[8*i +: 8];
            push_byte(d[8*i +: 8], s);
        end
        push_byte(x, s);
    endfunction

    task automatic wait_done(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || sched_busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL frame_timeout: got %0d bytes and %0d acks pending, required 0", exp_q.size(), ack_q.size());
        end
    endtask

    task automatic send_req(int i);
        int n = 0;
        @(negedge clk);
        src_req[i] = 1'b1;
        while (sched_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        src_req[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        vectors += 5;
        if (tx_start_out !== 1'b0) begin miscompares++; $display("FAIL %s tx_start_out: got %b, required 0", tag, tx_start_out); end
        if (tx_data_out !== 8'h00) begin miscompares++; $display("FAIL %s tx_data_out: got %h, required 00", tag, tx_data_out); end
        if (src_ack !== '0) begin miscompares++; $display("FAIL %s src_ack: got %b, required 0", tag, src_ack); end
        if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL %s sched_busy: got %b, required 0", tag, sched_busy); end
        if (cur_src !== 2'd0) begin miscompares++; $display("FAIL %s cur_src: got %0d, required 0", tag, cur_src); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        busy_len = 10;
        push_byte(8'hA5, 0); push_byte(8'h02, 0); push_byte(8'h12, 0); push_byte(8'h34, 0); push_byte(8'h24, 0);
        ack_q.push_back(3'b001);
        @(negedge clk);
        src_len[3:0] = 4'd2;
        src_data[63:0] = 64'h3412;
        src_req[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_start_out !== 1'b0 || sched_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_load: got start=%b busy=%b, required start=0 busy=1", tx_start_out, sched_busy);
        end
        @(negedge clk);
        vectors++;
        if (tx_start_out !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_send: got start=%b, required 1", tx_start_out);
        end
        src_req[0] = 1'b0;
        wait_done(2000);
    endtask

    task automatic test_round_robin();
        int acks = 0, n = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        busy_len = 2;
        for (int i = 0; i < N; i++) begin
            src_len[4*i +: 4] = 4'd1;
            src_data[64*i +: 64] = 64'h10 + 64'(i);
        end
        push_frame(0, 4'd1, 64'h10); push_frame(1, 4'd1, 64'h11); push_frame(2, 4'd1, 64'h12); push_frame(0, 4'd1, 64'h10);
        ack_q.push_back(3'b001); ack_q.push_back(3'b010); ack_q.push_back(3'b100); ack_q.push_back(3'b001);
        src_req = 3'b111;
        while (acks < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (src_ack !== '0) acks++;
        end
        src_req = '0;
        vectors++;
        if (acks != 4) begin
            miscompares++;
            $display("FAIL rr_acks: got %0d, required 4", acks);
        end
        wait_done(2000);
    endtask

    task automatic test_clamp();
        busy_len = 3;
        src_len[7:4] = 4'hF;
        src_data[127:64] = 64'h0807060504030201;
        push_byte(8'hA5, 1); push_byte(8'h18, 1);
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1);
        push_byte(8'h10, 1);
        ack_q.push_back(3'b010);
        send_req(1);
        wait_done(2000);
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int starts[$];
        busy_len = 0;
        src_len[11:8] = 4'd0;
        push_byte(8'hA5, 2); push_byte(8'h20, 2); push_byte(8'h20, 2);
        ack_q.push_back(3'b100);
        @(negedge clk);
        src_req[2] = 1'b1;
        while (starts.size() < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (sched_busy === 1'b1) src_req[2] = 1'b0;
            if (tx_start_out === 1'b1) starts.push_back(cyc);
        end
        vectors++;
        if (starts.size() != 3) begin
            miscompares++;
            $display("FAIL timeout_starts: got %0d, required 3", starts.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (starts[i] - starts[i-1] != TO + 2) begin
                    miscompares++;
                    $display("FAIL timeout_spacing: got %0d, required %0d", starts[i] - starts[i-1], TO + 2);
                end
            end
        end
        wait_done(2000);
    endtask

    task automatic test_reset_mid();
        int seen = 0, n = 0;
        busy_len = 4;
        src_len[3:0] = 4'd3;
        src_data[63:0] = 64'hCCBBAA;
        push_byte(8'hA5, 0); push_byte(8'h03, 0);
        @(negedge clk);
        src_req[0] = 1'b1;
        while (seen < 2 && n < 500) begin
            @(negedge clk);
            n++;
            if (sched_busy === 1'b1) src_req[0] = 1'b0;
            if (tx_start_out === 1'b1) seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        vectors += 2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_bytes: got %0d pending, required 0", exp_q.size());
        end
        if (sched_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle: got sched_busy=%b, required 0", sched_busy);
        end
    endtask

    task automatic test_snapshot();
        int n = 0;
        busy_len = 2;
        src_len[7:4] = 4'd3;
        src_data[127:64] = 64'h445566;
        push_frame(1, 4'd3, 64'h445566);
        ack_q.push_back(3'b010);
        @(negedge clk);
        src_req[1] = 1'b1;
        while (sched_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        src_req[1] = 1'b0;
        @(negedge clk);
        src_len[7:4] = 4'd8;
        src_data[127:64] = 64'hFFEEDDCCBBAA9988;
        wait_done(2000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_clamp();
        test_timeout();
        test_reset_mid();
        test_snapshot();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
